// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the serial sample-stream receiver.
//   byte_state_t  - byte FSM states (start/data/stop recovery)
//   frame_state_t - frame FSM states (sync hunt, high byte, low byte)
//   idx_width()   - width of a 0-based index that never collapses to 0 bits
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } byte_state_t;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } frame_state_t;

  localparam int         CLKS_PER_BIT_100M_115200 = 868;
  localparam logic [7:0] SYNC_BYTE_DEFAULT        = 8'hA5;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver (LSB first) with input synchronizer.
// Ports:
//   clk, rst     - system clock, async active-high reset
//   rx           - serial line, idle high, asynchronous to clk
//   byte_data    - last good byte, updated with byte_valid
//   byte_valid   - one-cycle pulse per byte with a good stop bit
//   framing_err  - one-cycle pulse when the stop bit samples low
`timescale 1ns/1ps
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_100M_115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int             CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);

  logic          sync1, rxs, rxs_d;
  logic          fall;
  byte_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Two-flop synchronizer; rxs_d is only used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign fall = rxs_d & ~rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // Mid start bit: a high line here means the edge was a glitch.
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt            <= '0;
            shreg[bit_idx] <= rxs;
            if (bit_idx == 3'd7) state   <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (rxs) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
              state      <= IDLE;
            end else begin
              // Stay out of IDLE until the line recovers so a held-low
              // break yields a single error, not one per byte time.
              framing_err <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_sample_rx.sv
// uart_sample_rx: decodes the sync-delimited serial sample stream.
// After a SYNC_BYTE, SAMPLES_PER_FRAME big-endian 16-bit samples follow.
// Ports:
//   clk, rst      - system clock, async active-high reset
//   uart_in       - serial line, idle high, asynchronous to clk
//   sample_data   - last assembled sample {hi, lo}, held between pulses
//   sample_valid  - one-cycle pulse with each new sample
//   sample_index  - 0-based position of sample_data in its frame
//   frame_done    - one-cycle pulse alongside the last sample of a frame
//   framing_err   - one-cycle pulse on a bad stop bit
//   byte_data     - last good byte (debug)
//   byte_valid    - one-cycle pulse per good byte (debug)
`timescale 1ns/1ps
module uart_sample_rx
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT      = CLKS_PER_BIT_100M_115200,
  parameter int         SAMPLES_PER_FRAME = 16,
  parameter logic [7:0] SYNC_BYTE         = SYNC_BYTE_DEFAULT,
  localparam int        IW                = idx_width(SAMPLES_PER_FRAME)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_in,
  output logic [15:0]   sample_data,
  output logic          sample_valid,
  output logic [IW-1:0] sample_index,
  output logic          frame_done,
  output logic          framing_err,
  output logic [7:0]    byte_data,
  output logic          byte_valid
);

  localparam logic [IW-1:0] LAST = IW'(SAMPLES_PER_FRAME - 1);

  frame_state_t  fstate;
  logic [7:0]    hi_byte;
  logic [IW-1:0] idx;

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_rx (
    .clk         (clk),
    .rst         (rst),
    .rx          (uart_in),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .framing_err (framing_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fstate       <= HUNT;
      hi_byte      <= '0;
      idx          <= '0;
      sample_data  <= '0;
      sample_index <= '0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      case (fstate)
        HUNT: begin
          if (byte_valid && byte_data == SYNC_BYTE) begin
            fstate <= HI;
            idx    <= '0;
          end
        end
        HI: begin
          // Inside a frame every byte is payload, including SYNC_BYTE.
          if (framing_err) begin
            fstate <= HUNT;
          end else if (byte_valid) begin
            hi_byte <= byte_data;
            fstate  <= LO;
          end
        end
        LO: begin
          if (framing_err) begin
            fstate <= HUNT;
          end else if (byte_valid) begin
            sample_data  <= {hi_byte, byte_data};
            sample_index <= idx;
            sample_valid <= 1'b1;
            if (idx == LAST) begin
              frame_done <= 1'b1;
              fstate     <= HUNT;
            end else begin
              idx    <= idx + 1'b1;
              fstate <= HI;
            end
          end
        end
        default: fstate <= HUNT;
      endcase
    end
  end

endmodule

// File: doc/uart_sample_rx.md
Name: uart_sample_rx

Overview:
- Ground-side or loopback receiver for the serial sample stream that data_buffer emits on uart_out.
- Recovers UART bytes (8N1, LSB first) from an asynchronous rx line.
- Locks onto a sync byte, then reassembles big-endian 16-bit ADC samples, presenting each one with a one-cycle valid pulse and its index within the frame.
- Used in the FPGA loopback bench and as the reusable decoder for downlink checking.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- SAMPLES_PER_FRAME, 16, 16-bit samples following each sync byte; must be >= 1.
- SYNC_BYTE, 8'hA5, frame delimiter byte.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- uart_in  in  1  serial line, idle high, asynchronous to clk.
- sample_data  out  16  last assembled sample, {high byte, low byte}.
- sample_valid  out  1  one-cycle pulse; sample_data is valid in that cycle.
- sample_index  out  $clog2(SAMPLES_PER_FRAME)  position of sample_data in the frame, 0-based.
- frame_done  out  1  one-cycle pulse, coincident with sample_valid of the last sample.
- framing_err  out  1  one-cycle pulse on a bad stop bit.
- byte_data  out  8  last received byte (debug).
- byte_valid  out  1  one-cycle pulse per good byte (debug).

Behaviour:
- Reset (async, active-high):
  - Synchronizer flops = 1.
  - Both FSMs go to IDLE / HUNT.
  - All counters = 0.
  - All outputs = 0.
- Input synchronizer: 2-FF synchronizer on uart_in. All logic below uses the second stage (rxs). A falling edge is detected against a third registered copy.
- Byte FSM:
  - IDLE: on a falling edge of rxs, go to START and clear the cycle counter.
  - START: at counter = CLKS_PER_BIT/2 - 1, sample rxs.
    - 0: go to DATA, clear counter and bit index.
    - 1: glitch; go to IDLE with no error.
  - DATA: at counter = CLKS_PER_BIT-1, shift rxs into bit[bit_idx] (LSB first) and clear the counter. After bit 7, go to STOP.
  - STOP: at counter = CLKS_PER_BIT-1, sample rxs.
    - 1: pulse byte_valid and update byte_data the next cycle; go to IDLE.
    - 0: pulse framing_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs = 1, then go to IDLE. A break condition therefore produces exactly one error.
- Frame FSM, advanced only on good bytes:
  - HUNT: byte == SYNC_BYTE → go to HI, index = 0. Any other byte is ignored.
  - HI: latch the high byte, go to LO. A byte equal to SYNC_BYTE here is treated as data, not resync.
  - LO: output sample_data = {hi, byte}, sample_index = index, pulse sample_valid.
    - index == SAMPLES_PER_FRAME-1: also pulse frame_done, go to HUNT.
    - Otherwise: index+1, go to HI.
- Latency: sample_valid rises 2 clk cycles after the stop-bit sample point of the low byte (1 for byte_valid, 1 for the frame register).
- sample_data and sample_index hold their values between pulses.
- A framing_err in HI or LO forces the frame FSM to HUNT and drops the partial sample and frame. No frame_done is issued.
- A falling edge during STOP/WAIT_IDLE is ignored; the next start is detected only from IDLE.
- Bit-timing tolerance: mid-bit sampling gives about ±4% baud mismatch over 10 bits.

Decomposition:
- Package uart_pkg holds:
  - byte FSM state enum {IDLE, START, DATA, STOP, WAIT_IDLE};
  - frame FSM state enum {HUNT, HI, LO};
  - default constants CLKS_PER_BIT_100M_115200 = 868 and SYNC_BYTE_DEFAULT = 8'hA5.
- One sub-module, uart_byte_rx: synchronizer plus byte FSM, producing byte_data/byte_valid/framing_err. The top level holds the frame assembler.

Test Plan:
- Reset mid-byte: assert rst during bit 3 of a byte, release, then send a clean frame → all outputs 0 during reset; no spurious byte; the following frame decodes correctly.
- Nominal frame (CLKS_PER_BIT=8): send A5, then 14 2E, 16 24, 17 FE, …, 1C 16 (16 samples: 5166, 5668, 6142 … 7190) → 16 sample_valid pulses with sample_data = 5166, 5668, 6142, …, 7190 and sample_index = 0..15; a single frame_done coincident with index 15.
- Garbage before sync: send 00 FF 3C, then a valid frame → no sample_valid until after A5; decode is identical to the nominal frame.
- Framing error: in frame 1, give the high byte of sample 5 a stop bit of 0 → one framing_err pulse; samples 0–4 are output and nothing further; no frame_done; the next A5 frame decodes fully.
- Glitch rejection: drive a 2-cycle low pulse on idle uart_in → no byte_valid and no framing_err.
- Break and baud skew: hold uart_in low for 30 bit times, then send a frame at +3% baud → exactly one framing_err for the break; the skewed frame decodes with all 16 samples correct.
